// File: rtl/mem_wb_stage.sv
// MEM stage with wait-state data memory and the MEM/WB pipeline register.
// Stall holds upstream stages while a load/store is in flight; WB sees bubbles meanwhile.
module mem_wb_stage #(
  parameter int DEPTH_WORDS = 64,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic        RegWriteM,
  input  logic [31:0] ALUResultAddrM,
  input  logic [31:0] DataWriteInM,
  input  logic [4:0]  RegisterDstM,
  output logic        Stall,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [4:0]  RegisterDstW
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'((MEM_LATENCY == 0) ? 0 : MEM_LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            complete;
  logic            access;
  logic [AW-1:0]   idx;
  logic [31:0]     mem_q [DEPTH_WORDS];

  assign access = MemReadM | MemWriteM;
  assign idx    = ALUResultAddrM[AW+1:2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    Stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && MEM_LATENCY != 0) begin
          Stall   = 1'b1;
          state_d = WAIT;
          cnt_d   = LAT_M1;
        end else begin
          complete = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          Stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset aborts any access in flight, including a pending store.
    if (reset) begin
      Stall    = 1'b0;
      complete = 1'b0;
      state_d  = IDLE;
      cnt_d    = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (complete && MemWriteM) mem_q[idx] <= DataWriteInM;
  end

  // Anything that is neither reset nor completion is a stall cycle: push a bubble.
  always_ff @(posedge clk) begin
    if (complete) begin
      RegWriteW    <= RegWriteM;
      MemtoRegW    <= MemtoRegM;
      ALUResultW   <= ALUResultAddrM;
      RegisterDstW <= RegisterDstM;
      ReadDataW    <= (MemReadM && !MemWriteM) ? mem_q[idx] : 32'd0;
    end else begin
      RegWriteW    <= 1'b0;
      MemtoRegW    <= 1'b0;
      ALUResultW   <= 32'd0;
      RegisterDstW <= 5'd0;
      ReadDataW    <= 32'd0;
    end
  end
endmodule
